// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents: code_t / onehot_t typedefs, the IDLE/HOLD state enum and
// onehot_of(), which expands a binary code into its one-hot line.
package dec_pkg;

  typedef logic [2:0] code_t;
  typedef logic [7:0] onehot_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_t;

  function automatic onehot_t onehot_of(input code_t code);
    onehot_of = onehot_t'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_3x8_seq_if.sv
// Handshake and output bundle between a code producer and the decoder.
// Latency: n/a (wires only).
// Backpressure: in_ready is driven by the decoder (slave side).
//
// Signals: en, in_valid, in_code (producer -> decoder);
//          in_ready, out, out_valid, busy (decoder -> producer/consumers).
interface decoder_3x8_seq_if;
  import dec_pkg::*;

  logic    en;
  logic    in_valid;
  logic    in_ready;
  code_t   in_code;
  onehot_t out;
  logic    out_valid;
  logic    busy;

  modport master (
    output en, in_valid, in_code,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  en, in_valid, in_code,
    output in_ready, out, out_valid, busy
  );

endinterface

// File: rtl/dec_hold_timer.sv
// Loadable down-counter with a zero flag; paces how long a decoded line is held.
// Latency: load/decrement visible one clock after the edge; zero is a decode of the register.
// Backpressure: none; it counts every clock until it reaches zero and then parks there.
//
// Ports: clk, rst (sync, active-high), load, load_val[W], zero.
module dec_hold_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority so a refill on the final hold cycle restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_3x8_seq.sv
// Registered 3-to-8 one-hot decoder that holds each decoded line for HOLD_CYCLES clocks.
// Latency: out is valid the clock after a transfer and stays up HOLD_CYCLES clocks.
// Backpressure: in_ready drops while a hold is running and only reopens on its last cycle.
//
// Ports: clk, rst (sync, active-high), bus (decoder_3x8_seq_if.slave:
//        en, in_valid, in_code -> in_ready, out, out_valid, busy).
// Optional macro DEC3X8_COUNT_EN adds dec_count[15:0], a wrapping count of accepted codes.
module decoder_3x8_seq
  import dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  decoder_3x8_seq_if.slave        bus
`ifdef DEC3X8_COUNT_EN
  ,
  output logic [15:0]             dec_count
`endif
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  dec_state_t state_q;
  onehot_t    out_q;
  onehot_t    out_d;
  logic       out_valid_q;
  logic       busy_q;
  logic       cnt_zero;
  logic       xfer;

  // cnt_zero is always true in IDLE, so ready reduces to en there; in HOLD
  // the last hold cycle reopens the input for a gap-free refill.
  assign bus.in_ready = bus.en && ((state_q == IDLE) || cnt_zero);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign out_d        = onehot_of(bus.in_code);

  dec_hold_timer #(
    .W (CW)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q     <= HOLD;
            out_q       <= out_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            if (xfer) begin
              out_q <= out_d;
            end else begin
              state_q     <= IDLE;
              out_q       <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

`ifdef DEC3X8_COUNT_EN
  logic [15:0] dec_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count_q <= '0;
    end else if (xfer) begin
      dec_count_q <= dec_count_q + 16'd1;
    end
  end

  assign dec_count = dec_count_q;
`endif

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
// Expected output values are queued per accepted code and popped once per clock.
// Honours DEC3X8_COUNT_EN when defined.
module tb_decoder_3x8_seq;

  logic clk;
  logic rst;
  logic chk_on;
  int   n_cmp;
  int   n_bad;

  // Expected out value for each upcoming cycle, one queue per instance.
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  int         acc_a;
  int         acc_b;

  decoder_3x8_seq_if ia ();
  decoder_3x8_seq_if ib ();

`ifdef DEC3X8_COUNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  decoder_3x8_seq #(.HOLD_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
`ifdef DEC3X8_COUNT_EN
    , .dec_count (cnt_a)
`endif
  );

  decoder_3x8_seq #(.HOLD_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
`ifdef DEC3X8_COUNT_EN
    , .dec_count (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard producers: a code is accepted when the bench itself believes
  // the decoder is ready (queue drained) and enable/valid are high.
  always @(posedge clk) begin
    if (rst) begin
      exp_a_q.delete();
      exp_b_q.delete();
      acc_a = 0;
      acc_b = 0;
    end else begin
      if (ia.en && ia.in_valid && exp_a_q.size() == 0) begin
        repeat (4) exp_a_q.push_back(8'h01 << ia.in_code);
        acc_a++;
      end
      if (ib.en && ib.in_valid && exp_b_q.size() == 0) begin
        exp_b_q.push_back(8'h01 << ib.in_code);
        acc_b++;
      end
    end
  end

  // Scoreboard consumers: one expected value per clock, zero when nothing queued.
  always @(negedge clk) begin
    logic [7:0] ea;
    logic [7:0] eb;
    if (chk_on) begin
      ea = (exp_a_q.size() != 0) ? exp_a_q.pop_front() : 8'h00;
      eb = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : 8'h00;
      chk("a.out",  32'(ia.out),       32'(ea));
      chk("a.vld",  32'(ia.out_valid), 32'(ea != 8'h00));
      chk("a.busy", 32'(ia.busy),      32'(ea != 8'h00));
      chk("a.rdy",  32'(ia.in_ready),  32'(ia.en && exp_a_q.size() == 0));
      chk("a.oh",   32'($onehot0(ia.out)), 32'(1));
      chk("b.out",  32'(ib.out),       32'(eb));
      chk("b.vld",  32'(ib.out_valid), 32'(eb != 8'h00));
      chk("b.busy", 32'(ib.busy),      32'(eb != 8'h00));
      chk("b.rdy",  32'(ib.in_ready),  32'(ib.en));
      chk("b.oh",   32'($onehot0(ib.out)), 32'(1));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    chk_on = 1'b0;
    acc_a  = 0;
    acc_b  = 0;
    rst    = 1'b1;
    ia.en = 1'b0; ia.in_valid = 1'b0; ia.in_code = 3'd0;
    ib.en = 1'b0; ib.in_valid = 1'b0; ib.in_code = 3'd0;
    cyc(2);
    rst    = 1'b0;
    chk_on = 1'b1;
    chk("rst.out",  32'(ia.out), 32'h0);
    chk("rst.busy", 32'(ia.busy), 32'h0);
`ifdef DEC3X8_COUNT_EN
    chk("rst.cnt", 32'(cnt_a), 32'h0);
`endif

    // Single code 5, 4-cycle hold.
    ia.en = 1'b1; ia.in_valid = 1'b1; ia.in_code = 3'd5;
    cyc(1);
    ia.in_valid = 1'b0; ia.in_code = 3'd2;
    chk("t1.out", 32'(ia.out), 32'h20);
    chk("t1.rdy", 32'(ia.in_ready), 32'h0);
    cyc(3);
    chk("t1.last", 32'(ia.out), 32'h20);
    chk("t1.rdy4", 32'(ia.in_ready), 32'h1);
    cyc(1);
    chk("t1.clr", 32'(ia.out), 32'h0);
    cyc(3);

    // Back-to-back codes 0,7,3 with in_valid held high.
    ia.in_valid = 1'b1;
    ia.in_code = 3'd0; cyc(4);
    ia.in_code = 3'd7; cyc(1);
    chk("t2.seam", 32'(ia.out), 32'h80);
    cyc(3);
    ia.in_code = 3'd3; cyc(4);
    ia.in_valid = 1'b0;
    cyc(6);

    // HOLD_CYCLES=1 streaming 0..7.
    ib.en = 1'b1; ib.in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ib.in_code = 3'(c);
      cyc(1);
    end
    ib.in_valid = 1'b0;
    cyc(3);
`ifdef DEC3X8_COUNT_EN
    chk("t3.cnt8", 32'(cnt_b), 32'd8);
`endif

    // en low blocks acceptance; dropping en mid-hold lets the hold finish.
    ia.en = 1'b0; ia.in_valid = 1'b1; ia.in_code = 3'd2;
    cyc(4);
    ia.en = 1'b1; ia.in_code = 3'd4;
    cyc(2);
    ia.en = 1'b0; ia.in_code = 3'd1;
    cyc(8);
    chk("t4.idle", 32'(ia.out), 32'h0);
    ia.en = 1'b1; ia.in_valid = 1'b0;
    cyc(2);

    // Reset on hold cycle 2 of code 6, with valid/en high at the reset edge.
    ia.in_valid = 1'b1; ia.in_code = 3'd6;
    cyc(1);
    ia.in_code = 3'd3;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("t5.out",  32'(ia.out), 32'h0);
    chk("t5.vld",  32'(ia.out_valid), 32'h0);
    chk("t5.busy", 32'(ia.busy), 32'h0);
`ifdef DEC3X8_COUNT_EN
    chk("t5.cnt", 32'(cnt_a), 32'h0);
`endif
    rst = 1'b0;
    ia.in_valid = 1'b0;
    cyc(2);

    // Every code with an idle gap, on both instances.
    for (int c = 0; c < 8; c++) begin
      ia.in_valid = 1'b1; ia.in_code = 3'(c);
      ib.in_valid = 1'b1; ib.in_code = 3'(7 - c);
      cyc(1);
      ia.in_valid = 1'b0; ib.in_valid = 1'b0;
      cyc(6);
    end

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      ia.en       = ($urandom_range(0, 3) != 0);
      ia.in_valid = $urandom_range(0, 1) != 0;
      ia.in_code  = 3'($urandom_range(0, 7));
      ib.en       = ($urandom_range(0, 3) != 0);
      ib.in_valid = $urandom_range(0, 1) != 0;
      ib.in_code  = 3'($urandom_range(0, 7));
      cyc(1);
    end
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    cyc(6);
`ifdef DEC3X8_COUNT_EN
    chk("end.cnt_a", 32'(cnt_a), 32'(acc_a[15:0]));
    chk("end.cnt_b", 32'(cnt_b), 32'(acc_b[15:0]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_3x8_seq.md
# decoder_3x8_seq

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and programmable output hold (pulse stretching). It accepts a 3-bit binary code and drives the matching one-hot line for exactly HOLD_CYCLES clocks, then releases it. It is the consumer-side counterpart of the team's 8x3 one-hot encoder: codes produced by an encoder are expanded back into timed one-hot select/strobe lines.

## Interface
- HOLD_CYCLES, 4, clocks each decoded line stays asserted; legal range 1..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  decoder enable; gates acceptance of new codes only.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  decoder can accept a code this cycle; combinational.
- in_code  input  3  binary code, 0..7.
- out  output  8  one-hot decoded value, or all zeros when idle.
- out_valid  output  1  high while out is non-zero.
- busy  output  1  high in HOLD state.
- dec_count  output  16  number of accepted codes; present only with DEC3X8_COUNT_EN.

## Operation
- Reset values: out=8'h00, out_valid=0, busy=0, state=IDLE, hold counter=0, dec_count=0.
- FSM states: IDLE, HOLD.
- Transfer occurs on a rising edge where in_valid && in_ready.
- in_ready = en && (state==IDLE || (state==HOLD && cnt==0)).
- IDLE: on transfer, the next edge sets out to 1<<in_code, out_valid=1, cnt=HOLD_CYCLES-1, and the state to HOLD. Without a transfer, the block stays in IDLE with out=0.
- HOLD, cnt>0: cnt decrements each clock; out is held stable; in_ready=0.
- HOLD, cnt==0, transfer: out switches directly to the new one-hot value with no zero gap; cnt reloads to HOLD_CYCLES-1; the state stays HOLD.
- HOLD, cnt==0, no transfer: the next edge clears out to 0, clears out_valid, and returns to IDLE.
- en deasserted mid-hold: the current hold completes normally; no new code is accepted; the block then returns to IDLE.
- in_code is sampled only on transfer; changes at other times are ignored.
- Invariant: out is always zero or exactly one-hot; out_valid == (out != 0); busy == (state==HOLD).
- rst during HOLD: the next edge forces all reset values, regardless of in_valid and en.
- rst and a transfer in the same cycle: rst wins and the code is dropped.

## Timing
- Latency: transfer at edge N -> out valid from after edge N through edge N+HOLD_CYCLES; clears after edge N+HOLD_CYCLES if not refilled.
- Throughput: one code per HOLD_CYCLES clocks when in_valid is held high.
- HOLD_CYCLES=1: in_ready equals en in every state; one code per clock; out changes every cycle.
- Outputs out, out_valid and busy are registered. in_ready is the only combinational output, and it is independent of in_valid (no combinational loop).

## Configuration
- Macro DEC3X8_COUNT_EN.
- Defined: the dec_count port exists. It increments by 1 on every transfer, wraps 16'hFFFF -> 16'h0000, and is cleared by rst.
- Undefined: neither the port nor the counter logic exists; all other behaviour is identical.

## Structure
- Shared package dec_pkg holds:
  - typedef code_t (3 bits) and onehot_t (8 bits);
  - state enum dec_state_t {IDLE, HOLD};
  - function onehot_of(code_t) returning 1<<code.
- The hold counter width is derived in the module as $clog2(HOLD_CYCLES+1).
- One natural sub-module, dec_hold_timer: loadable down-counter with a zero flag. The FSM and output register stay in the top.

## Test plan
- Reset, then in_code=3'd5 with in_valid=1, HOLD_CYCLES=4 -> out=8'h20 for exactly 4 cycles, then 8'h00. in_ready is low for cycles 1-3 of the hold and high on cycle 4.
- in_valid held high with codes 0,7,3 back to back, HOLD_CYCLES=4 -> out=01,01,01,01,80,80,80,80,08,08,08,08 with no zero cycle between codes.
- HOLD_CYCLES=1 with codes 0..7 streamed each cycle -> out walks 01,02,04,...,80, one per clock. With DEC3X8_COUNT_EN, dec_count=8 afterwards.
- en=0 with in_valid=1 -> in_ready=0 and out stays 0. Drop en mid-hold -> the hold completes, then out returns to 0 and no new code is taken.
- rst asserted on hold cycle 2 of code 6 -> the next edge gives out=0, out_valid=0, busy=0, and dec_count=0 when the macro is defined.
- Exhaustive check of all 8 codes, each followed by an idle gap -> each produces the correct single bit. The one-hot/zero invariant and out_valid==(out!=0) hold on every cycle.
